// File: rtl/rx_pkg.sv
// Shared types and defaults for the interpreter byte receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

    localparam int DEFAULT_WORD_COUNT  = 256;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous strobe into clk and emits a one-cycle rising-edge pulse.
// Latency: pulse appears STAGES clk edges after the input rises.
// Backpressure: none; every synchronized rising edge produces exactly one pulse.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              edge_q;
    logic              edge_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        edge_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign rise_pulse = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/interpreter_receiver.sv
// Assembles interpreter bytes (little-endian) into 32-bit words and writes them to RAM.
// Latency: wren one clk after the 4th byte of a word is sampled; DONE one clk after the last wren.
// Backpressure: none; ack_out toggles per accepted byte so the interpreter can pace itself.
module interpreter_receiver
    import rx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WORD_COUNT  = DEFAULT_WORD_COUNT,
    parameter int          SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startIO,
    input  logic        clk_in,
    input  logic [7:0]  DataIn,
    output logic [31:0] address,
    output logic [31:0] data,
    output logic        wren,
    output logic        ack_out,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LAST_WORD = 16'(WORD_COUNT - 1);

    rx_state_e   state_q, state_d;
    logic        start_prev_q, start_prev_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic        wren_q, wren_d;
    logic        last_q, last_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        byte_valid;
    logic        start_rise;

    sync_edge_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (clk_in),
        .rise_pulse(byte_valid)
    );

    assign start_rise = startIO & ~start_prev_q;

    always_comb begin
        state_d      = state_q;
        start_prev_d = startIO;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        data_d       = data_q;
        addr_d       = addr_q;
        wren_d       = 1'b0;
        last_d       = last_q;
        ack_d        = ack_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d    = RECV;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    last_d     = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            RECV: begin
                // Assembly keeps running during the wren cycle so back-to-back bytes are never dropped.
                if (byte_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = DataIn;
                    ack_d      = ~ack_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        data_d     = {DataIn, asm_q[23:0]};
                        addr_d     = BASE_ADDR + {16'h0000, word_idx_q};
                        wren_d     = 1'b1;
                        word_idx_d = word_idx_q + 16'd1;
                        last_d     = (word_idx_q == LAST_WORD);
                    end
                end
                if (wren_q && last_q) begin
                    state_d = DONE;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            // Treat startIO as already high so a level held across reset cannot start a session.
            start_prev_q <= 1'b1;
            byte_idx_q   <= 2'd0;
            word_idx_q   <= 16'd0;
            asm_q        <= 32'd0;
            data_q       <= 32'd0;
            addr_q       <= 32'd0;
            wren_q       <= 1'b0;
            last_q       <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            wren_q       <= wren_d;
            last_q       <= last_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign address = addr_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign ack_out = ack_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_interpreter_receiver.sv
// Scoreboard bench: two receivers (base 0x10 and base 0xFFFF_FFFF, two words each) share stimulus.
// Expected RAM writes are queued per instance and popped by monitors on every wren.
module tb_interpreter_receiver;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        startIO;
    logic        clk_in;
    logic [7:0]  DataIn;

    logic [31:0] address_a, data_a, address_b, data_b;
    logic        wren_a, ack_a, busy_a, done_a;
    logic        wren_b, ack_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    wr_t exp_a[$];
    wr_t exp_b[$];

    int  toggles_a = 0;
    int  toggles_b = 0;
    logic ack_a_prev = 1'b0;
    logic ack_b_prev = 1'b0;
    logic wren_a_prev = 1'b0;
    logic wren_b_prev = 1'b0;

    interpreter_receiver #(
        .BASE_ADDR  (32'h0000_0010),
        .WORD_COUNT (2),
        .SYNC_STAGES(SYNC)
    ) dut_a (
        .clk    (clk),
        .reset  (reset),
        .startIO(startIO),
        .clk_in (clk_in),
        .DataIn (DataIn),
        .address(address_a),
        .data   (data_a),
        .wren   (wren_a),
        .ack_out(ack_a),
        .busy   (busy_a),
        .done   (done_a)
    );

    interpreter_receiver #(
        .BASE_ADDR  (32'hFFFF_FFFF),
        .WORD_COUNT (2),
        .SYNC_STAGES(SYNC)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .startIO(startIO),
        .clk_in (clk_in),
        .DataIn (DataIn),
        .address(address_b),
        .data   (data_b),
        .wren   (wren_b),
        .ack_out(ack_b),
        .busy   (busy_b),
        .done   (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitors: pop expected writes on wren, flag unexpected or stretched pulses, count ack toggles.
    always @(negedge clk) begin
        if (wren_a_prev === 1'b1) check("wren_a_single_cycle", {31'd0, wren_a}, 32'd0);
        if (wren_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("wren_a_unexpected", {31'd0, wren_a}, 32'd0);
            end else begin
                wr_t e;
                e = exp_a.pop_front();
                check("addr_a", address_a, e.addr);
                check("data_a", data_a, e.data);
            end
        end
        if (ack_a !== ack_a_prev) toggles_a++;
        ack_a_prev  = ack_a;
        wren_a_prev = wren_a;
    end

    always @(negedge clk) begin
        if (wren_b_prev === 1'b1) check("wren_b_single_cycle", {31'd0, wren_b}, 32'd0);
        if (wren_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("wren_b_unexpected", {31'd0, wren_b}, 32'd0);
            end else begin
                wr_t e;
                e = exp_b.pop_front();
                check("addr_b", address_b, e.addr);
                check("data_b", data_b, e.data);
            end
        end
        if (ack_b !== ack_b_prev) toggles_b++;
        ack_b_prev  = ack_b;
        wren_b_prev = wren_b;
    end

    // One byte every 4 clk (SYNC+2) plus extra idle cycles; DataIn set one clk before the strobe rises.
    task automatic send_byte(input logic [7:0] b, input int extra);
        @(posedge clk); #1 DataIn = b;
        @(posedge clk); #1 clk_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 clk_in = 1'b0;
        repeat (extra) @(posedge clk);
    endtask

    task automatic start_session();
        @(posedge clk); #1 startIO = 1'b0;
        @(posedge clk); #1 startIO = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_a_started", {31'd0, busy_a}, 32'd1);
        check("done_a_cleared", {31'd0, done_a}, 32'd0);
        check("busy_b_started", {31'd0, busy_b}, 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_address_a"}, address_a, 32'd0);
        check({tag, "_data_a"}, data_a, 32'd0);
        check({tag, "_wren_a"}, {31'd0, wren_a}, 32'd0);
        check({tag, "_ack_a"}, {31'd0, ack_a}, 32'd0);
        check({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_done_a"}, {31'd0, done_a}, 32'd0);
        check({tag, "_address_b"}, address_b, 32'd0);
        check({tag, "_busy_b"}, {31'd0, busy_b}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_a;
        int base_b;
        logic [7:0] w0 [4];
        reset   = 1'b0;
        startIO = 1'b1;
        clk_in  = 1'b0;
        DataIn  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("in_reset");

        // startIO held high across reset release must not start a session.
        @(posedge clk); #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_cleared("after_release");

        // Strobe in IDLE is ignored.
        send_byte(8'hAA, 2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("idle_ack_a", {31'd0, ack_a}, 32'd0);
        check("idle_busy_a", {31'd0, busy_a}, 32'd0);

        // Partial word then reset: nothing stale may be written afterwards.
        start_session();
        send_byte(8'h78, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("first_byte_ack_a", {31'd0, ack_a}, 32'd1);
        send_byte(8'h56, 2);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_cleared("mid_reset");
        @(posedge clk); #1 reset = 1'b1;

        // Full session at minimum strobe spacing.
        start_session();
        base_a = toggles_a;
        base_b = toggles_b;
        exp_a.push_back('{addr: 32'h0000_0010, data: 32'h1234_5678});
        exp_a.push_back('{addr: 32'h0000_0011, data: 32'hDEAD_BEEF});
        exp_b.push_back('{addr: 32'hFFFF_FFFF, data: 32'h1234_5678});
        exp_b.push_back('{addr: 32'h0000_0000, data: 32'hDEAD_BEEF});
        w0[0] = 8'h78; w0[1] = 8'h56; w0[2] = 8'h34; w0[3] = 8'h12;
        for (int i = 0; i < 4; i++) send_byte(w0[i], 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("s1_done_a", {31'd0, done_a}, 32'd1);
        check("s1_busy_a", {31'd0, busy_a}, 32'd0);
        check("s1_ack_a", {31'd0, ack_a}, 32'd0);
        check("s1_toggles_a", toggles_a - base_a, 32'd8);
        check("s1_done_b", {31'd0, done_b}, 32'd1);
        check("s1_toggles_b", toggles_b - base_b, 32'd8);
        check("s1_pending_a", exp_a.size(), 32'd0);
        check("s1_pending_b", exp_b.size(), 32'd0);

        // Strobe in DONE is ignored.
        send_byte(8'h55, 2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("done_ack_a", {31'd0, ack_a}, 32'd0);
        check("done_hold_a", {31'd0, done_a}, 32'd1);

        // Second session from DONE with relaxed spacing.
        start_session();
        base_a = toggles_a;
        exp_a.push_back('{addr: 32'h0000_0010, data: 32'h0403_0201});
        exp_a.push_back('{addr: 32'h0000_0011, data: 32'h0807_0605});
        exp_b.push_back('{addr: 32'hFFFF_FFFF, data: 32'h0403_0201});
        exp_b.push_back('{addr: 32'h0000_0000, data: 32'h0807_0605});
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 3);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("s2_done_a", {31'd0, done_a}, 32'd1);
        check("s2_busy_a", {31'd0, busy_a}, 32'd0);
        check("s2_toggles_a", toggles_a - base_a, 32'd8);
        check("s2_done_b", {31'd0, done_b}, 32'd1);
        check("s2_pending_a", exp_a.size(), 32'd0);
        check("s2_pending_b", exp_b.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
